// File: rtl/mac_seq.sv
// Segment sequencer feeding mac_5: queues segment descriptors and plays each
// one out as a t ramp 0..len-1, holding its coefficients and gain steady.
module mac_seq #(
  parameter int BC = 16,
  parameter int BT = 12,
  parameter int BY = 10,
  parameter int BF = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [6*BC+BY+BT-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   stop,
  output logic [BT-1:0]          t_out,
  output logic [BC-1:0]          c0_out,
  output logic [BC-1:0]          c1_out,
  output logic [BC-1:0]          c2_out,
  output logic [BC-1:0]          c3_out,
  output logic [BC-1:0]          c4_out,
  output logic [BC-1:0]          c5_out,
  output logic [BY-1:0]          g_out,
  output logic                   t_valid,
  output logic                   last,
  output logic                   busy
);

  localparam int DW    = 6*BC + BY + BT;
  localparam int DEPTH = 1 << BF;
  localparam int G_LSB = 6*BC;
  localparam int L_LSB = 6*BC + BY;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [BF-1:0]     wr_ptr_q, rd_ptr_q;
  logic [BF:0]       count_q, count_d;
  logic              ready_q, ready_d;
  logic              push_s, pop_s;
  logic [DW-1:0]     head_s;
  logic [BT-1:0]     t_q, t_d, len_q, len_d;
  logic [BC-1:0]     c_q [6];
  logic [BC-1:0]     c_d [6];
  logic [BY-1:0]     g_q, g_d;
  logic              valid_q, valid_d, last_q, last_d, busy_q, busy_d;

  // ready is registered from the post-update count, so a full FIFO never
  // reopens on the same cycle it is popped; stop gates it combinationally
  assign s_tready = ready_q & ~stop;
  assign push_s   = s_tvalid & s_tready;
  assign head_s   = mem_q[rd_ptr_q];

  always_comb begin
    state_d = IDLE;
    pop_s   = 1'b0;
    t_d     = '0;
    len_d   = len_q;
    g_d     = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    busy_d  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c_d[i] = c_q[i];
    end
    if (stop) begin
      state_d = IDLE;
    end else if (state_q == RUN && !last_q) begin
      state_d = RUN;
      t_d     = t_q + BT'(1);
      g_d     = g_q;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      last_d  = ((t_q + BT'(1)) == (len_q - BT'(1)));
    end else if (count_q != '0) begin
      // idle, or the final sample of a segment: start the next one seamlessly
      state_d = RUN;
      pop_s   = 1'b1;
      len_d   = head_s[L_LSB +: BT];
      g_d     = head_s[G_LSB +: BY];
      valid_d = 1'b1;
      busy_d  = 1'b1;
      last_d  = (head_s[L_LSB +: BT] == BT'(1));
      for (int i = 0; i < 6; i++) begin
        c_d[i] = head_s[i*BC +: BC];
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_comb begin
    count_d = count_q;
    if (stop) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{BF{1'b0}}, push_s} - {{BF{1'b0}}, pop_s};
    end
    ready_d = (count_d != (BF+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      t_q      <= '0;
      len_q    <= '0;
      g_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        c_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      t_q      <= t_d;
      len_q    <= len_d;
      g_q      <= g_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      for (int i = 0; i < 6; i++) begin
        c_q[i] <= c_d[i];
      end
      if (stop) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_q + BF'(push_s);
        rd_ptr_q <= rd_ptr_q + BF'(pop_s);
      end
    end
  end

  assign t_out   = t_q;
  assign c0_out  = c_q[0];
  assign c1_out  = c_q[1];
  assign c2_out  = c_q[2];
  assign c3_out  = c_q[3];
  assign c4_out  = c_q[4];
  assign c5_out  = c_q[5];
  assign g_out   = g_q;
  assign t_valid = valid_q;
  assign last    = last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: a queue-based segment model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_mac_seq;
  localparam int BC = 16;
  localparam int BT = 12;
  localparam int BY = 10;
  localparam int BF = 2;

  typedef struct packed {
    logic [BT-1:0]        len;
    logic [BY-1:0]        g;
    logic [5:0][BC-1:0]   c;
  } desc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, s_tvalid, s_tready, stop;
  desc_t         din;
  logic [BT-1:0] t_out;
  logic [BC-1:0] c0_out, c1_out, c2_out, c3_out, c4_out, c5_out;
  logic [BY-1:0] g_out;
  logic          t_valid, last, busy;

  mac_seq #(.BC(BC), .BT(BT), .BY(BY), .BF(BF)) dut (
    .clk(clk), .rstn(rstn), .s_tdata(din), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .stop(stop), .t_out(t_out), .c0_out(c0_out), .c1_out(c1_out), .c2_out(c2_out),
    .c3_out(c3_out), .c4_out(c4_out), .c5_out(c5_out), .g_out(g_out),
    .t_valid(t_valid), .last(last), .busy(busy)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic desc_t mk(input logic [15:0] a0, input logic [15:0] a1,
                               input logic [15:0] a2, input logic [15:0] a3,
                               input logic [15:0] a4, input logic [15:0] a5,
                               input logic [9:0] gg, input logic [11:0] ll);
    desc_t d;
    d.c[0] = a0; d.c[1] = a1; d.c[2] = a2; d.c[3] = a3; d.c[4] = a4; d.c[5] = a5;
    d.g = gg;
    d.len = ll;
    return d;
  endfunction

  // final sample index of a segment: len-1 modulo 2**BT, so len=0 plays 4096
  function automatic bit is_last(input int tt, input logic [11:0] ll);
    return tt == ((int'(ll) + 4095) % 4096);
  endfunction

  // ---------------- model ----------------
  desc_t         mq[$];
  desc_t         cur;
  bit            play = 1'b0;
  bit            rdy_en = 1'b0;
  bit            acc;
  int            t = 0;
  logic [15:0]   ec [6];

  initial begin
    forever begin
      @(posedge clk);
      if (!rstn) begin
        mq.delete();
        play = 1'b0;
        t = 0;
        rdy_en = 1'b0;
        cur = '0;
        for (int i = 0; i < 6; i++) ec[i] = 16'd0;
      end else begin
        acc = s_tvalid && rdy_en && !stop && (mq.size() < 4);
        if (stop) begin
          mq.delete();
          play = 1'b0;
        end else begin
          if (play && !is_last(t, cur.len)) begin
            t++;
          end else if (mq.size() > 0) begin
            cur = mq.pop_front();
            play = 1'b1;
            t = 0;
            for (int i = 0; i < 6; i++) ec[i] = cur.c[i];
          end else begin
            play = 1'b0;
          end
          if (acc) mq.push_back(din);
        end
        rdy_en = 1'b1;
      end
      @(negedge clk);
      chk("m_tvalid", t_valid, play);
      chk("m_busy", busy, play);
      chk("m_last", last, play && is_last(t, cur.len));
      chk("m_tout", t_out, play ? t : 0);
      chk("m_gout", g_out, play ? cur.g : 10'd0);
      chk("m_c0", c0_out, ec[0]);
      chk("m_c1", c1_out, ec[1]);
      chk("m_c2", c2_out, ec[2]);
      chk("m_c3", c3_out, ec[3]);
      chk("m_c4", c4_out, ec[4]);
      chk("m_c5", c5_out, ec[5]);
      chk("m_tready", s_tready, rdy_en && !stop && (mq.size() < 4));
    end
  end

  // ---------------- driver ----------------
  task automatic push(input desc_t d);
    bit ok;
    ok = 1'b0;
    din = d;
    s_tvalid = 1'b1;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    chk("push_handshake", ok, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!t_valid) break;
    end
    chk("idle_timeout", t_valid, 1'b0);
  endtask

  desc_t a_d, b_d;
  int    n, nl;
  logic [11:0] exp_t [5];
  logic [9:0]  exp_g [5];
  logic        exp_l [5];

  initial begin
    rstn = 1'b0;
    stop = 1'b0;
    s_tvalid = 1'b1;
    din = mk(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 10'd7, 12'd8);

    // reset with s_tvalid high: nothing accepted, everything 0
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_tvalid", t_valid, 1'b0);
    chk("rst_c3", c3_out, 16'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("rdy_pre", s_tready, 1'b0);
    @(negedge clk);
    chk("rdy_rel", s_tready, 1'b1);
    chk("rel_tvalid", t_valid, 1'b0);
    @(posedge clk);
    #1;

    // single segment, len=5
    push(mk(16'd1234, -16'sd626, 16'sd16062, -16'sd17029, 16'sd9481, -16'sd3793, 10'd511, 12'd5));
    @(negedge clk);
    chk("s1_lat", t_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s1_tvalid", t_valid, 1'b1);
      chk("s1_tout", t_out, k);
      chk("s1_last", last, k == 4);
      chk("s1_c1", c1_out, 16'hFD8E);
      chk("s1_c2", c2_out, 16'd16062);
      chk("s1_g", g_out, 10'd511);
    end
    @(negedge clk);
    chk("s1_end_tvalid", t_valid, 1'b0);
    chk("s1_end_g", g_out, 10'd0);
    chk("s1_hold_c5", c5_out, 16'hF12F);
    @(posedge clk);
    #1;

    // back-to-back A(len=3), B(len=2)
    a_d = mk(16'd100, 16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 10'd7, 12'd3);
    b_d = mk(16'd200, 16'd201, 16'd202, 16'd203, 16'd204, 16'd205, 10'd9, 12'd2);
    exp_t = '{12'd0, 12'd1, 12'd2, 12'd0, 12'd1};
    exp_g = '{10'd7, 10'd7, 10'd7, 10'd9, 10'd9};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    push(a_d);
    push(b_d);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bb_tvalid", t_valid, 1'b1);
      chk("bb_tout", t_out, exp_t[k]);
      chk("bb_g", g_out, exp_g[k]);
      chk("bb_last", last, exp_l[k]);
      chk("bb_c0", c0_out, (k < 3) ? 16'd100 : 16'd200);
    end
    @(negedge clk);
    chk("bb_end", t_valid, 1'b0);
    @(posedge clk);
    #1;

    // backpressure: 5 accepted then s_tready low until first segment ends
    for (int i = 0; i < 6; i++) begin
      push(mk(16'(i), 16'(i + 10), 16'd0, 16'd0, 16'd0, 16'd0, 10'(i + 1), 12'd1000));
      if (i == 4) begin
        @(negedge clk);
        chk("bp_full", s_tready, 1'b0);
      end
    end
    wait_idle(8000);
    @(posedge clk);
    #1;

    // len=0 plays 4096 samples
    push(mk(16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 10'd3, 12'd0));
    n = 0;
    nl = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (t_valid) begin
        n++;
        if (last) nl++;
      end else if (n > 0) begin
        break;
      end
    end
    chk("len0_count", n, 4096);
    chk("len0_lasts", nl, 1);
    @(posedge clk);
    #1;

    // stop at t_out=10 with two queued, simultaneous s_tvalid refused
    for (int i = 0; i < 3; i++) begin
      push(mk(16'(i + 50), 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 10'(i + 20), 12'd50));
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (t_valid && t_out == 12'd9) break;
    end
    chk("stop_reach9", t_out, 12'd9);
    @(posedge clk);
    #1;
    stop = 1'b1;
    s_tvalid = 1'b1;
    din = mk(16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 10'd77, 12'd4);
    @(negedge clk);
    chk("stop_tready", s_tready, 1'b0);
    chk("stop_t10", t_out, 12'd10);
    @(posedge clk);
    #1;
    stop = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("stop_tvalid", t_valid, 1'b0);
    chk("stop_g", g_out, 10'd0);
    chk("stop_busy", busy, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stop_flushed", t_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    push(mk(16'd300, 16'd301, 16'd302, 16'd303, 16'd304, 16'd305, 10'd33, 12'd3));
    @(negedge clk);
    chk("post_lat", t_valid, 1'b0);
    @(negedge clk);
    chk("post_tvalid", t_valid, 1'b1);
    chk("post_t0", t_out, 12'd0);
    chk("post_c0", c0_out, 16'd300);
    wait_idle(20);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
